// File: rtl/wb_select_ctrl.sv
// Write-back select controller for the multi-cycle KGP-RISC datapath: drives the 3:1 write-back mux select
// and the register-file write port. Optional load-wait timeout is enabled by defining WB_TIMEOUT_EN.
module wb_select_ctrl #(
    parameter int ZERO_REG_HARDWIRED = 1,
    parameter int TIMEOUT_CYCLES     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wb_req,
    input  logic [1:0] wb_kind,
    input  logic [4:0] wb_rd,
    input  logic       mem_ready,
    output logic       wb_busy,
    output logic [1:0] sel,
    output logic       rf_we,
    output logic [4:0] rf_waddr,
    output logic       wb_done,
    output logic       err_overrun,
    output logic       err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_LOAD_WAIT = 3'd2,
        S_LOAD_WB   = 3'd3,
        S_NOWB      = 3'd4
    } state_e;

    state_e     state_q;
    logic       busy_q;
    logic [1:0] sel_q;
    logic       rf_we_q;
    logic [4:0] rf_waddr_q;
    logic       wb_done_q;
    logic       err_overrun_q;
    logic       timeout_s;

    function automatic logic we_allowed(input logic [4:0] rd);
        return !((ZERO_REG_HARDWIRED != 0) && (rd == 5'd0));
    endfunction

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("wb_select_ctrl: TIMEOUT_CYCLES must fit the 8-bit wait counter");
    end

`ifdef WB_TIMEOUT_EN
    logic [7:0] to_cnt_q;
    logic [7:0] to_cnt_d;
    logic       err_timeout_q;

    assign to_cnt_d  = to_cnt_q + 8'd1;
    assign timeout_s = (to_cnt_d == 8'(TIMEOUT_CYCLES));

    // Wait counter: zero outside LOAD_WAIT, so it starts from zero on every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= 8'd0;
        end else if (state_q == S_LOAD_WAIT) begin
            to_cnt_q <= to_cnt_d;
        end else begin
            to_cnt_q <= 8'd0;
        end
    end

    // Sticky timeout flag; a late mem_ready on the limit cycle takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_timeout_q <= 1'b0;
        end else if ((state_q == S_LOAD_WAIT) && !mem_ready && timeout_s) begin
            err_timeout_q <= 1'b1;
        end else begin
            err_timeout_q <= err_timeout_q;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign timeout_s   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Control FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            sel_q         <= 2'b00;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= 5'd0;
            wb_done_q     <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            if (wb_req && busy_q) begin
                err_overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (wb_req) begin
                        rf_waddr_q <= wb_rd;
                        busy_q     <= 1'b1;
                        case (wb_kind)
                            2'b00, 2'b10: begin
                                state_q   <= S_WRITE;
                                sel_q     <= wb_kind;
                                rf_we_q   <= we_allowed(wb_rd);
                                wb_done_q <= 1'b1;
                            end
                            2'b01: begin
                                state_q   <= S_LOAD_WAIT;
                                sel_q     <= 2'b01;
                                rf_we_q   <= 1'b0;
                                wb_done_q <= 1'b0;
                            end
                            default: begin
                                state_q   <= S_NOWB;
                                sel_q     <= 2'b00;
                                rf_we_q   <= 1'b0;
                                wb_done_q <= 1'b1;
                            end
                        endcase
                    end else begin
                        busy_q    <= 1'b0;
                        rf_we_q   <= 1'b0;
                        wb_done_q <= 1'b0;
                    end
                end
                S_LOAD_WAIT: begin
                    if (mem_ready) begin
                        state_q   <= S_LOAD_WB;
                        rf_we_q   <= we_allowed(rf_waddr_q);
                        wb_done_q <= 1'b1;
                    end else if (timeout_s) begin
                        // Abandoned load retires like a no-write-back instruction.
                        state_q   <= S_NOWB;
                        sel_q     <= 2'b00;
                        rf_we_q   <= 1'b0;
                        wb_done_q <= 1'b1;
                    end else begin
                        state_q   <= S_LOAD_WAIT;
                    end
                end
                S_WRITE, S_LOAD_WB, S_NOWB: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    rf_we_q   <= 1'b0;
                    wb_done_q <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    rf_we_q   <= 1'b0;
                    wb_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign wb_busy     = busy_q;
    assign sel         = sel_q;
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign wb_done     = wb_done_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_wb_select_ctrl.sv
// Directed self-checking bench for wb_select_ctrl; expected values are hand-computed from the
// cycle-level behaviour (acceptance at edge N, write-back visible in cycle N+1).
module tb_wb_select_ctrl;

    logic       clk;
    logic       rst;
    logic       wb_req;
    logic [1:0] wb_kind;
    logic [4:0] wb_rd;
    logic       mem_ready;
    logic       wb_busy;
    logic [1:0] sel;
    logic       rf_we;
    logic [4:0] rf_waddr;
    logic       wb_done;
    logic       err_overrun;
    logic       err_timeout;

    int checks_r;
    int failures_r;

    wb_select_ctrl #(
        .ZERO_REG_HARDWIRED(1),
        .TIMEOUT_CYCLES    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_req     (wb_req),
        .wb_kind    (wb_kind),
        .wb_rd      (wb_rd),
        .mem_ready  (mem_ready),
        .wb_busy    (wb_busy),
        .sel        (sel),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .wb_done    (wb_done),
        .err_overrun(err_overrun),
        .err_timeout(err_timeout)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [1:0] kind, input logic [4:0] rd);
        wb_req  = 1'b1;
        wb_kind = kind;
        wb_rd   = rd;
        tick();
        wb_req  = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic busy_e, input logic [1:0] sel_e,
                              input logic we_e, input logic [4:0] addr_e, input logic done_e);
        check_val({tag, ".busy"},  {31'd0, wb_busy}, {31'd0, busy_e});
        check_val({tag, ".sel"},   {30'd0, sel},     {30'd0, sel_e});
        check_val({tag, ".we"},    {31'd0, rf_we},   {31'd0, we_e});
        check_val({tag, ".waddr"}, {27'd0, rf_waddr}, {27'd0, addr_e});
        check_val({tag, ".done"},  {31'd0, wb_done}, {31'd0, done_e});
    endtask

    initial begin
        checks_r   = 0;
        failures_r = 0;
        rst        = 1'b0;
        wb_req     = 1'b0;
        wb_kind    = 2'b00;
        wb_rd      = 5'd0;
        mem_ready  = 1'b0;
        tick();
        tick();
        check_outs("reset", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        check_val("reset.ovr", {31'd0, err_overrun}, 32'd0);
        check_val("reset.to",  {31'd0, err_timeout}, 32'd0);
        rst = 1'b1;
        tick();

        // ALU write to r5
        request(2'b00, 5'd5);
        check_outs("alu", 1'b1, 2'b00, 1'b1, 5'd5, 1'b1);
        tick();
        check_outs("alu_idle", 1'b0, 2'b00, 1'b0, 5'd5, 1'b0);

        // Load to r9; mem_ready at acceptance must not count
        mem_ready = 1'b1;
        request(2'b01, 5'd9);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_outs("load_wait", 1'b1, 2'b01, 1'b0, 5'd9, 1'b0);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check_outs("load_wb", 1'b1, 2'b01, 1'b1, 5'd9, 1'b1);
        tick();
        check_outs("load_idle", 1'b0, 2'b01, 1'b0, 5'd9, 1'b0);

        // mem_ready while idle is ignored
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check_outs("stray_ready", 1'b0, 2'b01, 1'b0, 5'd9, 1'b0);

        // Link to r31
        request(2'b10, 5'd31);
        check_outs("link", 1'b1, 2'b10, 1'b1, 5'd31, 1'b1);
        tick();
        check_outs("link_idle", 1'b0, 2'b10, 1'b0, 5'd31, 1'b0);

        // ALU write to r0 is suppressed but still retires
        request(2'b00, 5'd0);
        check_outs("zero", 1'b1, 2'b00, 1'b0, 5'd0, 1'b1);
        tick();

        // No write-back kind
        request(2'b11, 5'd7);
        check_outs("nowb", 1'b1, 2'b00, 1'b0, 5'd7, 1'b1);
        tick();
        check_outs("nowb_idle", 1'b0, 2'b00, 1'b0, 5'd7, 1'b0);
        check_val("no_ovr_yet", {31'd0, err_overrun}, 32'd0);

        // Overrun during LOAD_WAIT: second request lost
        request(2'b01, 5'd3);
        request(2'b00, 5'd12);
        check_val("ovr_set", {31'd0, err_overrun}, 32'd1);
        check_outs("ovr_wait", 1'b1, 2'b01, 1'b0, 5'd3, 1'b0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check_outs("ovr_wb", 1'b1, 2'b01, 1'b1, 5'd3, 1'b1);
        tick();
        check_outs("ovr_idle", 1'b0, 2'b01, 1'b0, 5'd3, 1'b0);
        tick();
        check_outs("ovr_lost", 1'b0, 2'b01, 1'b0, 5'd3, 1'b0);
        check_val("ovr_sticky", {31'd0, err_overrun}, 32'd1);

        // Reset mid-load
        request(2'b01, 5'd20);
        tick();
        rst = 1'b0;
        #1;
        check_outs("rst_async", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        check_val("rst_ovr", {31'd0, err_overrun}, 32'd0);
        mem_ready = 1'b1;
        tick();
        check_outs("rst_hold", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        rst = 1'b1;
        tick();
        check_outs("rst_rel1", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        tick();
        check_outs("rst_rel2", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        mem_ready = 1'b0;
        tick();

        // Load with memory never ready
        request(2'b01, 5'd14);
`ifdef WB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            check_outs("to_wait", 1'b1, 2'b01, 1'b0, 5'd14, 1'b0);
            tick();
        end
        check_val("to_done", {31'd0, wb_done}, 32'd1);
        check_val("to_we",   {31'd0, rf_we},   32'd0);
        check_val("to_err",  {31'd0, err_timeout}, 32'd1);
        tick();
        check_val("to_idle",   {31'd0, wb_busy},     32'd0);
        check_val("to_sticky", {31'd0, err_timeout}, 32'd1);
`else
        for (int i = 0; i < 20; i++) begin
            check_outs("hang_wait", 1'b1, 2'b01, 1'b0, 5'd14, 1'b0);
            tick();
        end
        check_val("hang_to", {31'd0, err_timeout}, 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check_outs("hang_wb", 1'b1, 2'b01, 1'b1, 5'd14, 1'b1);
        tick();
        check_val("hang_idle", {31'd0, wb_busy}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
